// File: rtl/conv_pkg.sv
// conv_pkg: definitions shared across the convolution datapath.
//   stage_t         - 3-bit stage code driven by the conv controller and
//                     observed by the kernel array and the output collector.
//   collect_state_t - state of the output collector's row serializer.
package conv_pkg;

    typedef enum logic [2:0] {
        STAGE_INIT  = 3'd0,
        STAGE_LOAD  = 3'd1,
        STAGE_SHIFT = 3'd2,
        STAGE_MAC   = 3'd3,
        STAGE_ACCUM = 3'd4,
        STAGE_BIAS  = 3'd5,
        STAGE_DRAIN = 3'd6,
        STAGE_IDLE  = 3'd7
    } stage_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } collect_state_t;

endpackage

// File: rtl/conv_output_collector_if.sv
// conv_output_collector_if: valid/ready word stream from the output collector
// to the result buffer.
//   o_data  - result word
//   o_addr  - feature-map address of o_data (row*ARRAY_SIZE+col)
//   o_valid - o_data/o_addr valid
//   i_ready - sink accepts the word when o_valid && i_ready
// Modports: master (collector side), slave (result buffer side).
interface conv_output_collector_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 6
);
    logic [WIDTH-1:0]  o_data;
    logic [ADDR_W-1:0] o_addr;
    logic              o_valid;
    logic              i_ready;

    modport master (
        output o_data,
        output o_addr,
        output o_valid,
        input  i_ready
    );

    modport slave (
        input  o_data,
        input  o_addr,
        input  o_valid,
        output i_ready
    );
endinterface

// File: rtl/conv_strobe_delay.sv
// conv_strobe_delay: DEPTH-stage single-bit shift register with synchronous
// clear, used to delay the row-capture strobe until the array accumulators
// have settled.
//   clk, rst_n - clock, asynchronous active-low reset
//   clr        - synchronous clear of every stage
//   din        - strobe in
//   dout       - strobe out, DEPTH cycles later
//   any        - at least one stage holds a strobe
module conv_strobe_delay #(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic din,
    output logic dout,
    output logic any
);

    logic [DEPTH-1:0] pipe_reg;
    logic [DEPTH-1:0] pipe_next;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        if (gi == 0) begin : g_first
            assign pipe_next[gi] = din;
        end else begin : g_rest
            assign pipe_next[gi] = pipe_reg[gi-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_reg <= '0;
        end else if (clr) begin
            pipe_reg <= '0;
        end else begin
            pipe_reg <= pipe_next;
        end
    end

    assign dout = pipe_reg[DEPTH-1];
    assign any  = |pipe_reg;

endmodule

// File: rtl/conv_output_collector.sv
// conv_output_collector: captures the ARRAY_SIZE-wide accumulator bus once per
// row pass (CAPTURE_DELAY cycles after the controller enters STAGE_BIAS) and
// serializes it into an addressed valid/ready word stream.
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   current_state  - stage code from the conv controller (conv_pkg::stage_t)
//   i_pixel_bus    - accumulator bus, column 0 in the MSB slice
//   stream         - word stream (master): o_data, o_addr, o_valid, i_ready
//   o_row_done     - pulse after the last word of a row is accepted
//   o_frame_done   - pulse after the last word of the last row is accepted
//   o_overrun      - sticky: a capture arrived while a row was still sending
//   o_busy         - serializer sending or a capture still in the pipeline
// Build option: CONV_COLLECT_RELU_EN - negative words are output as zero
// (applied on o_data only, the shadow keeps raw accumulator values).
module conv_output_collector
    import conv_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int KERNEL_SIZE   = 3,
    parameter int IMAGE_SIZE    = 8,
    parameter int ARRAY_SIZE    = 6,
    parameter int CAPTURE_DELAY = 3,
    parameter int OUT_ROWS      = IMAGE_SIZE - KERNEL_SIZE + 1,
    parameter int ADDR_W        = $clog2(OUT_ROWS * ARRAY_SIZE)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [2:0]                  current_state,
    input  logic [ARRAY_SIZE*WIDTH-1:0] i_pixel_bus,
    conv_output_collector_if.master     stream,
    output logic                        o_row_done,
    output logic                        o_frame_done,
    output logic                        o_overrun,
    output logic                        o_busy
);

    localparam int COL_W = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
    localparam int ROW_W = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1;

    // ---------------------------------------------------------------
    // Capture timing: edge-detect entry into STAGE_BIAS, then delay.
    // ---------------------------------------------------------------
    logic [2:0] prev_state_reg;
    logic       abort;
    logic       strobe;
    logic       capture;
    logic       pipe_busy;

    assign abort  = (current_state == 3'(STAGE_INIT));
    assign strobe = (current_state == 3'(STAGE_BIAS)) &&
                    (prev_state_reg != 3'(STAGE_BIAS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_state_reg <= 3'(STAGE_INIT);
        end else begin
            prev_state_reg <= current_state;
        end
    end

    conv_strobe_delay #(
        .DEPTH(CAPTURE_DELAY)
    ) u_strobe_delay (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (abort),
        .din  (strobe),
        .dout (capture),
        .any  (pipe_busy)
    );

    // ---------------------------------------------------------------
    // Serializer state
    // ---------------------------------------------------------------
    collect_state_t              state_reg, state_next;
    logic [COL_W-1:0]            col_reg, col_next;
    logic [ROW_W-1:0]            row_reg, row_next;
    logic [ARRAY_SIZE*WIDTH-1:0] shadow_reg, shadow_next;
    logic                        overrun_reg, overrun_next;
    logic                        row_done_reg, row_done_next;
    logic                        frame_done_reg, frame_done_next;

    logic handshake;
    logic last_word;
    logic last_row;

    // A word offered during an abort cycle is not considered accepted.
    assign handshake = (state_reg == S_SEND) && stream.i_ready && !abort;
    assign last_word = handshake && (col_reg == COL_W'(ARRAY_SIZE - 1));
    assign last_row  = (row_reg == ROW_W'(OUT_ROWS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            col_reg        <= '0;
            row_reg        <= '0;
            shadow_reg     <= '0;
            overrun_reg    <= 1'b0;
            row_done_reg   <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            col_reg        <= col_next;
            row_reg        <= row_next;
            shadow_reg     <= shadow_next;
            overrun_reg    <= overrun_next;
            row_done_reg   <= row_done_next;
            frame_done_reg <= frame_done_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        col_next        = col_reg;
        row_next        = row_reg;
        shadow_next     = shadow_reg;
        overrun_next    = overrun_reg;
        row_done_next   = 1'b0;
        frame_done_next = 1'b0;

        if (abort) begin
            state_next   = S_IDLE;
            col_next     = '0;
            row_next     = '0;
            overrun_next = 1'b0;
        end else begin
            if (handshake) begin
                if (last_word) begin
                    row_done_next   = 1'b1;
                    frame_done_next = last_row;
                    row_next        = last_row ? '0 : row_reg + ROW_W'(1);
                    col_next        = '0;
                    state_next      = S_IDLE;
                end else begin
                    col_next = col_reg + COL_W'(1);
                end
            end

            // The shadow is free either when idle or when its final word
            // leaves in this very cycle, which gives gap-free back-to-back rows.
            if (capture) begin
                if ((state_reg == S_IDLE) || last_word) begin
                    shadow_next = i_pixel_bus;
                    col_next    = '0;
                    state_next  = S_SEND;
                end else begin
                    overrun_next = 1'b1;
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Output word selection (column 0 lives in the MSB slice)
    // ---------------------------------------------------------------
    logic [WIDTH-1:0] words [ARRAY_SIZE];
    logic [WIDTH-1:0] sel_word;

    for (genvar gi = 0; gi < ARRAY_SIZE; gi++) begin : g_word
        assign words[gi] = shadow_reg[(ARRAY_SIZE-1-gi)*WIDTH +: WIDTH];
    end

    assign sel_word = words[col_reg];

`ifdef CONV_COLLECT_RELU_EN
    assign stream.o_data = sel_word[WIDTH-1] ? '0 : sel_word;
`else
    assign stream.o_data = sel_word;
`endif

    assign stream.o_addr  = ADDR_W'(row_reg) * ADDR_W'(ARRAY_SIZE) + ADDR_W'(col_reg);
    assign stream.o_valid = (state_reg == S_SEND);

    assign o_row_done   = row_done_reg;
    assign o_frame_done = frame_done_reg;
    assign o_overrun    = overrun_reg;
    assign o_busy       = (state_reg == S_SEND) || pipe_busy;

endmodule

// File: tb/tb_conv_output_collector.sv
// tb_conv_output_collector: directed and random stimulus for
// conv_output_collector, checked each cycle against a queue-based model:
// pending captures are kept as a list of due cycles and the row in flight as
// a queue of the words still to be delivered.
module tb_conv_output_collector;
    import conv_pkg::*;

    localparam int W      = 32;
    localparam int AS     = 6;
    localparam int CDLY   = 3;
    localparam int ROWS   = 6;
    localparam int ADDR_W = 6;

    logic              clk;
    logic              rst_n;
    logic [2:0]        current_state;
    logic [AS*W-1:0]   pixel_bus;
    logic              row_done;
    logic              frame_done;
    logic              overrun;
    logic              busy;

    conv_output_collector_if #(.WIDTH(W), .ADDR_W(ADDR_W)) stream_if ();

    conv_output_collector #(
        .WIDTH(W), .KERNEL_SIZE(3), .IMAGE_SIZE(8), .ARRAY_SIZE(AS),
        .CAPTURE_DELAY(CDLY), .OUT_ROWS(ROWS), .ADDR_W(ADDR_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .current_state(current_state),
        .i_pixel_bus  (pixel_bus),
        .stream       (stream_if),
        .o_row_done   (row_done),
        .o_frame_done (frame_done),
        .o_overrun    (overrun),
        .o_busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    // Reference model state
    logic [W-1:0] m_q[$];     // words of the current row not yet accepted
    int           m_cap[$];   // cycles at which pending captures fall due
    int           m_row;
    bit           m_over, m_rd, m_fd;
    logic [2:0]   m_prev;

    function automatic logic [W-1:0] relu(input logic [W-1:0] w);
`ifdef CONV_COLLECT_RELU_EN
        return w[W-1] ? '0 : w;
`else
        return w;
`endif
    endfunction

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance the model across one clock edge with the given inputs.
    task automatic model_update(input logic [2:0] st, input logic [AS*W-1:0] bus, input bit rdy);
        bit hs, last, cap;
        cyc++;
        if (st == STAGE_INIT) begin
            m_q.delete();
            m_cap.delete();
            m_row  = 0;
            m_over = 0;
            m_rd   = 0;
            m_fd   = 0;
        end else begin
            hs   = (m_q.size() > 0) && rdy;
            last = hs && (m_q.size() == 1);
            cap  = 0;
            if (hs) void'(m_q.pop_front());
            if (m_cap.size() > 0 && m_cap[0] == cyc) begin
                cap = 1;
                void'(m_cap.pop_front());
            end
            if (st == STAGE_BIAS && m_prev != STAGE_BIAS) m_cap.push_back(cyc + CDLY);
            m_rd = last;
            m_fd = last && (m_row == ROWS - 1);
            if (last) m_row = (m_row + 1) % ROWS;
            if (cap) begin
                if (m_q.size() == 0) begin
                    for (int c = 0; c < AS; c++) m_q.push_back(bus[(AS-1-c)*W +: W]);
                end else begin
                    m_over = 1;
                end
            end
        end
        m_prev = st;
    endtask

    task automatic compare_outputs();
        int n;
        n = m_q.size();
        check_val("valid",      64'(stream_if.o_valid), 64'(n > 0));
        check_val("busy",       64'(busy),              64'((n > 0) || (m_cap.size() > 0)));
        check_val("overrun",    64'(overrun),           64'(m_over));
        check_val("row_done",   64'(row_done),          64'(m_rd));
        check_val("frame_done", 64'(frame_done),        64'(m_fd));
        check_val("addr",       64'(stream_if.o_addr),  64'(m_row * AS + ((n > 0) ? (AS - n) : 0)));
        if (n > 0) check_val("data", 64'(stream_if.o_data), 64'(relu(m_q[0])));
    endtask

    // Called just after a falling edge: drive inputs, step model, check.
    task automatic step(input logic [2:0] st, input logic [AS*W-1:0] bus, input bit rdy);
        current_state      = st;
        pixel_bus          = bus;
        stream_if.i_ready  = rdy;
        if (m_q.size() > 0 && rdy && st != STAGE_INIT)
            $display("xfer cycle=%0d addr=%0d data=%08h", cyc + 1,
                     m_row * AS + (AS - m_q.size()), relu(m_q[0]));
        model_update(st, bus, rdy);
        @(negedge clk);
        compare_outputs();
    endtask

    function automatic logic [AS*W-1:0] rand_bus();
        logic [AS*W-1:0] b;
        for (int c = 0; c < AS; c++) b[c*W +: W] = $urandom;
        return b;
    endfunction

    logic [AS*W-1:0] bus_a, bus_b;
    logic [2:0]      other_stages [6];
    logic [2:0]      st;
    int              r;

    initial begin
        other_stages[0] = STAGE_LOAD;  other_stages[1] = STAGE_SHIFT;
        other_stages[2] = STAGE_MAC;   other_stages[3] = STAGE_ACCUM;
        other_stages[4] = STAGE_DRAIN; other_stages[5] = STAGE_IDLE;

        rst_n             = 1'b0;
        current_state     = STAGE_IDLE;
        pixel_bus         = '0;
        stream_if.i_ready = 1'b0;
        m_row = 0; m_over = 0; m_rd = 0; m_fd = 0; m_prev = STAGE_INIT;

        @(negedge clk);
        @(negedge clk);
        check_val("rst_valid",      64'(stream_if.o_valid), 64'(0));
        check_val("rst_row_done",   64'(row_done),          64'(0));
        check_val("rst_frame_done", 64'(frame_done),        64'(0));
        check_val("rst_overrun",    64'(overrun),           64'(0));
        check_val("rst_busy",       64'(busy),              64'(0));
        check_val("rst_data",       64'(stream_if.o_data),  64'(0));
        check_val("rst_addr",       64'(stream_if.o_addr),  64'(0));
        rst_n = 1'b1;

        // Single row 0x11..0x66, sink always ready
        bus_a = {32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66};
        for (int i = 0; i < 3; i++)  step(STAGE_BIAS, bus_a, 1'b1);
        for (int i = 0; i < 12; i++) step(STAGE_IDLE, bus_a, 1'b1);

        // Ready toggling every cycle during a row
        bus_a = rand_bus();
        step(STAGE_BIAS, bus_a, 1'b0);
        for (int i = 0; i < 20; i++) step(STAGE_IDLE, bus_a, (i % 2) == 0);

        // Full frame plus a seventh row
        step(STAGE_INIT, '0, 1'b1);
        for (int e = 0; e < 7; e++) begin
            bus_a = rand_bus();
            step(STAGE_BIAS, bus_a, 1'b1);
            for (int i = 0; i < 9; i++) step(STAGE_IDLE, bus_a, 1'b1);
        end

        // Overrun while stalled, then abort
        step(STAGE_INIT, '0, 1'b0);
        bus_a = rand_bus();
        step(STAGE_BIAS, bus_a, 1'b0);
        for (int i = 0; i < 5; i++) step(STAGE_IDLE, bus_a, 1'b0);
        bus_b = rand_bus();
        step(STAGE_BIAS, bus_b, 1'b0);
        for (int i = 0; i < 8; i++) step(STAGE_IDLE, bus_b, 1'b0);
        step(STAGE_INIT, bus_b, 1'b1);
        for (int i = 0; i < 3; i++) step(STAGE_IDLE, bus_b, 1'b1);

        // Capture coinciding with the last-word handshake
        step(STAGE_INIT, '0, 1'b1);
        bus_a = rand_bus();
        step(STAGE_BIAS, bus_a, 1'b1);
        for (int i = 0; i < 5; i++) step(STAGE_IDLE, bus_a, 1'b1);
        bus_b = rand_bus();
        step(STAGE_BIAS, bus_b, 1'b1);
        for (int i = 0; i < 12; i++) step(STAGE_IDLE, bus_b, 1'b1);

        // Negative and positive floats through the optional ReLU
        bus_a = rand_bus();
        bus_a[(AS-1)*W +: W] = 32'hBF80_0000;
        bus_a[(AS-2)*W +: W] = 32'h3F80_0000;
        step(STAGE_BIAS, bus_a, 1'b1);
        for (int i = 0; i < 10; i++) step(STAGE_IDLE, bus_a, 1'b1);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2)       st = STAGE_INIT;
            else if (r < 10) st = STAGE_BIAS;
            else             st = other_stages[$urandom_range(0, 5)];
            step(st, rand_bus(), $urandom_range(0, 3) != 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
